// File: rtl/fft_pkg.sv
// Shared FFT definitions: complex sample type, per-stage info record,
// streamer FSM state encoding and a bit-reverse helper.
package fft_pkg;

  localparam int FFT_DATA_WIDTH = 16;

  // Complex sample; re sits in the upper half when packed.
  typedef struct packed {
    logic [FFT_DATA_WIDTH-1:0] re;
    logic [FFT_DATA_WIDTH-1:0] im;
  } complex_t;

  // Butterfly stage bookkeeping shared with the FFT core.
  typedef struct packed {
    logic [4:0]  stage;
    logic [15:0] span;
    logic        last_stage;
  } stage_info_t;

  // Result streamer FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } stream_state_e;

  // Reverse the low 'width' bits of 'value'; bits above 'width' come back 0.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) r[5'(width - 1 - i)] = value[5'(i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_result_streamer_if.sv
// Output bin stream of the FFT result streamer.
//
// Handshake: a bin transfers on every rising clk edge where m_valid and
// m_ready are both high. Once m_valid is raised it stays high, and m_re,
// m_im, m_index and m_last stay unchanged, until that transfer happens.
// m_valid never depends combinationally on m_ready.
interface fft_result_streamer_if #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 16
);
  localparam int AW = $clog2(N);

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_re;
  logic [DATA_WIDTH-1:0] m_im;
  logic [AW-1:0]         m_index;
  logic                  m_last;

  modport master (output m_valid, m_re, m_im, m_index, m_last, input m_ready);
  modport slave  (input m_valid, m_re, m_im, m_index, m_last, output m_ready);
endinterface

// File: rtl/fft_stream_fifo.sv
// Two-entry register FIFO holding {bin data, bin index, last flag}.
// slot0 is always the head; a push into a full FIFO without a pop is dropped
// (the streamer never issues one).
import fft_pkg::*;

module fft_stream_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_W      = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic [2*DATA_WIDTH-1:0] push_data_i,
  input  logic [IDX_W-1:0]        push_idx_i,
  input  logic                    push_last_i,
  input  logic                    pop_i,
  output logic [1:0]              count_o,
  output logic [2*DATA_WIDTH-1:0] head_data_o,
  output logic [IDX_W-1:0]        head_idx_o,
  output logic                    head_last_o
);

  typedef struct packed {
    logic [2*DATA_WIDTH-1:0] data;
    logic [IDX_W-1:0]        idx;
    logic                    last;
  } entry_t;

  entry_t     slot0_q, slot0_d, slot1_q, slot1_d, in_e;
  logic [1:0] count_q, count_d;
  logic       pop_ok, push_ok;

  // Next-state of the two slots and the occupancy.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    in_e    = '{data: push_data_i, idx: push_idx_i, last: push_last_i};
    pop_ok  = pop_i && (count_q != 2'd0);
    push_ok = push_i && ((count_q != 2'd2) || pop_ok);
    case ({push_ok, pop_ok})
      2'b10: begin
        if (count_q == 2'd0) slot0_d = in_e;
        else                 slot1_d = in_e;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        slot1_d = '0;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          slot0_d = in_e;
        end else begin
          slot0_d = slot1_q;
          slot1_d = in_e;
        end
      end
      default: ;
    endcase
  end

  // Slot and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= '0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  assign head_data_o = slot0_q.data;
  assign head_idx_o  = slot0_q.idx;
  assign head_last_o = slot0_q.last;

endmodule

// File: rtl/fft_result_streamer.sv
// FFT result streamer: after the core's finish pulse, reads the N result
// bins from the bank (1-cycle read latency) and streams them out one bin per
// valid/ready handshake with index and last flag.
// Optional macro FFT_STREAM_BITREV_EN: read addresses are the bit-reversed
// issue counter so a bit-reversed bank streams in natural order.
import fft_pkg::*;

module fft_result_streamer #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fft_done,
  output logic                     mem_rd,
  output logic [$clog2(N)-1:0]     mem_addr,
  input  logic [2*DATA_WIDTH-1:0]  mem_q,
  fft_result_streamer_if.master    m_if,
  output logic                     busy,
  output logic                     overrun,
  output stream_state_e            dbg_state_o
);

  localparam int            AW       = $clog2(N);
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  stream_state_e           state_q, state_d;
  logic [AW-1:0]           issue_cnt_q, issue_cnt_d;
  logic [AW-1:0]           rd_idx_q;
  logic                    inflight_q;
  logic                    overrun_q;
  logic                    rd_en, pop, vld;
  logic [2:0]              occ;

  logic [1:0]              fifo_count;
  logic [2*DATA_WIDTH-1:0] head_data;
  logic [AW-1:0]           head_idx;
  logic                    head_last;

  // FSM next state, read issue and issue-counter advance.
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    rd_en       = 1'b0;
    vld         = (fifo_count != 2'd0);
    pop         = vld && m_if.m_ready;
    // Buffered plus in-flight entries: a new read is allowed only while this
    // stays below 2, or when a pop frees a slot in the same cycle.
    occ         = {1'b0, fifo_count} + {2'b00, inflight_q};
    case (state_q)
      IDLE: begin
        if (fft_done) begin
          state_d     = ISSUE;
          issue_cnt_d = '0;
        end
      end
      ISSUE: begin
        rd_en = (occ < 3'd2) || pop;
        if (rd_en) begin
          issue_cnt_d = issue_cnt_q + AW'(1);
          if (issue_cnt_q == LAST_IDX) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read address: natural or bit-reversed issue counter.
  always_comb begin
`ifdef FFT_STREAM_BITREV_EN
    mem_addr = AW'(bitrev(32'(issue_cnt_q), AW));
`else
    mem_addr = issue_cnt_q;
`endif
  end

  // State, counters, read pipeline tag and overrun pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      rd_idx_q    <= '0;
      inflight_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      inflight_q  <= rd_en;
      if (rd_en) rd_idx_q <= issue_cnt_q;
      overrun_q   <= fft_done && (state_q != IDLE);
    end
  end

  fft_stream_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (AW)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (inflight_q),
    .push_data_i (mem_q),
    .push_idx_i  (rd_idx_q),
    .push_last_i (rd_idx_q == LAST_IDX),
    .pop_i       (pop),
    .count_o     (fifo_count),
    .head_data_o (head_data),
    .head_idx_o  (head_idx),
    .head_last_o (head_last)
  );

  assign mem_rd         = rd_en;
  assign m_if.m_valid   = vld;
  assign m_if.m_re      = vld ? head_data[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
  assign m_if.m_im      = vld ? head_data[DATA_WIDTH-1:0] : '0;
  assign m_if.m_index   = vld ? head_idx : '0;
  assign m_if.m_last    = vld && head_last;
  assign busy           = (state_q != IDLE);
  assign overrun        = overrun_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_fft_result_streamer.sv
// Bench for fft_result_streamer: bank model with 1-cycle read latency,
// per-frame expected-bin queue and throughput/occupancy reference model.
`timescale 1ns/1ps
module tb_fft_result_streamer;
  import fft_pkg::*;

  localparam int N  = 8;
  localparam int DW = 16;
  localparam int AW = $clog2(N);
  localparam int BW = 2*DW + AW + 1;

  // ---------------- clock / reset / DUT ----------------
  logic            clk      = 1'b0;
  logic            rst_n    = 1'b0;
  logic            fft_done = 1'b0;
  logic            mem_rd;
  logic [AW-1:0]   mem_addr;
  logic [2*DW-1:0] mem_q    = '0;
  logic            busy;
  logic            overrun;
  stream_state_e   dbg_state;

  fft_result_streamer_if #(.N(N), .DATA_WIDTH(DW)) m_if ();

  fft_result_streamer #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fft_done    (fft_done),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_q       (mem_q),
    .m_if        (m_if),
    .busy        (busy),
    .overrun     (overrun),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  // Result bank: registered read, data valid the cycle after mem_rd.
  logic [2*DW-1:0] ram [N];
  always @(posedge clk) if (mem_rd) mem_q <= ram[mem_addr];

  // ---------------- scoreboard / reference model ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [BW-1:0] exp_q[$];
  bit          mdl_busy, exp_ovr, p1, hold_vld;
  logic [BW-1:0] hold_val;
  int          issued, popped, landed;
  int          ovr_seen, rd_seen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Bank address holding natural bin k.
  function automatic int addr_of(input int k);
`ifdef FFT_STREAM_BITREV_EN
    int r;
    r = 0;
    for (int b = 0; b < AW; b++) if (k[b]) r = r | (1 << (AW - 1 - b));
    return r;
`else
    return k;
`endif
  endfunction

  task automatic model_clear();
    mdl_busy = 0; exp_ovr = 0; p1 = 0; hold_vld = 0;
    issued = 0; popped = 0; landed = 0;
    exp_q.delete();
  endtask

  // Called once per cycle after inputs settle; checks outputs, then advances
  // the model to what the next rising edge produces.
  task automatic monitor();
    logic          pop, exp_rd, was_busy;
    logic [BW-1:0] cur, e;
    pop      = m_if.m_valid && m_if.m_ready;
    was_busy = mdl_busy;
    cur      = {m_if.m_re, m_if.m_im, m_if.m_index, m_if.m_last};

    check("overrun", 64'(overrun), 64'(exp_ovr));
    if (overrun) ovr_seen++;
    check("busy", 64'(busy), 64'(mdl_busy));
    check("m_valid", 64'(m_if.m_valid), 64'((landed - popped) > 0));
    if (m_if.m_valid && exp_q.size() > 0) begin
      e = exp_q[0];
      check("m_re",    64'(m_if.m_re),    64'(e[BW-1 -: DW]));
      check("m_im",    64'(m_if.m_im),    64'(e[BW-1-DW -: DW]));
      check("m_index", 64'(m_if.m_index), 64'(e[AW:1]));
      check("m_last",  64'(m_if.m_last),  64'(e[0]));
    end
    if (hold_vld) check("hold", 64'(cur), 64'(hold_val));
    hold_vld = m_if.m_valid && !m_if.m_ready;
    hold_val = cur;

    exp_rd = mdl_busy && (issued < N) && (((issued - popped) < 2) || pop);
    check("mem_rd", 64'(mem_rd), 64'(exp_rd));
    if (mem_rd) begin
      check("mem_addr", 64'(mem_addr), 64'(addr_of(issued)));
      issued++;
      rd_seen++;
    end
    if (pop && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      popped++;
      if (e[0]) mdl_busy = 0;
    end
    landed  = landed + int'(p1);
    p1      = mem_rd;
    exp_ovr = fft_done && was_busy;
    if (fft_done && !was_busy) begin
      mdl_busy = 1; issued = 0; popped = 0; landed = 0; p1 = 0;
      exp_q.delete();
      for (int k = 0; k < N; k++)
        exp_q.push_back({ram[addr_of(k)], AW'(k), (k == N - 1)});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic r, input logic d);
    @(negedge clk);
    m_if.m_ready = r;
    fft_done     = d;
    #1;
    monitor();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; fft_done = 1'b0; m_if.m_ready = 1'b1;
    @(negedge clk);
    #1;
    check("rst_m_valid",  64'(m_if.m_valid), 64'(0));
    check("rst_m_re",     64'(m_if.m_re),    64'(0));
    check("rst_m_im",     64'(m_if.m_im),    64'(0));
    check("rst_m_index",  64'(m_if.m_index), 64'(0));
    check("rst_m_last",   64'(m_if.m_last),  64'(0));
    check("rst_mem_rd",   64'(mem_rd),       64'(0));
    check("rst_mem_addr", 64'(mem_addr),     64'(0));
    check("rst_busy",     64'(busy),         64'(0));
    check("rst_overrun",  64'(overrun),      64'(0));
    check("rst_state",    64'(dbg_state),    64'(IDLE));
    rst_n = 1'b1;
    model_clear();
  endtask

  function automatic logic ready_for(input int mode, input int t);
    case (mode)
      0:       return 1'b1;
      1:       return (t > 20);
      2:       return (t % 2) == 1;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic preload_ramp();
    for (int i = 0; i < N; i++) ram[i] = {DW'(i), DW'(-i)};
  endtask

  task automatic preload_random();
    for (int i = 0; i < N; i++) ram[i] = 32'($urandom);
  endtask

  // Pulse fft_done and stream one frame. inject: beat number at which a
  // second fft_done is pulsed (-1 none). rst_at: beat at which reset hits.
  task automatic run_frame(input int mode, input int inject, input int rst_at,
                           output int cycles, output int stall_reads);
    int   t;
    bit   sent;
    logic d;
    t = 0; sent = 0; stall_reads = 0; ovr_seen = 0; rd_seen = 0;
    cycle(1'b1, 1'b1);
    while (mdl_busy && t < 200) begin
      t++;
      if (rst_at >= 0 && popped == rst_at) begin
        do_reset();
        cycles = t;
        return;
      end
      d = (inject >= 0) && (popped == inject) && !sent;
      if (d) sent = 1;
      cycle(ready_for(mode, t), d);
      if (t == 20) stall_reads = rd_seen;
    end
    if (mdl_busy) check("frame_timeout", 64'(0), 64'(1));
    check("frame_beats", 64'(popped), 64'(N));
    cycles = t;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int cyc, sr;
    m_if.m_ready = 1'b1;
    model_clear();
    preload_ramp();
    do_reset();
    repeat (2) cycle(1'b1, 1'b0);

    // Ready tied high: full rate, frame completes in N+2 cycles.
    run_frame(0, -1, -1, cyc, sr);
    check("frame_len", 64'(cyc), 64'(N + 2));
    cycle(1'b1, 1'b0);
    check("busy_after", 64'(busy), 64'(0));
    repeat (3) cycle(1'b1, 1'b0);

    // Long stall: at most 2 reads outstanding/buffered while blocked.
    run_frame(1, -1, -1, cyc, sr);
    check("stall_reads_le2", 64'(sr <= 2), 64'(1));
    repeat (3) cycle(1'b1, 1'b0);

    // Ready toggling every cycle.
    run_frame(2, -1, -1, cyc, sr);
    repeat (3) cycle(1'b1, 1'b0);

    // Second finish pulse mid-frame: one overrun pulse, frame unchanged.
    run_frame(0, 3, -1, cyc, sr);
    check("overrun_pulses", 64'(ovr_seen), 64'(1));
    repeat (3) cycle(1'b1, 1'b0);

    // Finish pulse on the same edge as the final handshake.
    run_frame(0, N - 1, -1, cyc, sr);
    cycle(1'b1, 1'b0);
    check("ovr_last_idle", 64'(busy), 64'(0));
    check("ovr_last_pulses", 64'(ovr_seen), 64'(1));
    repeat (3) cycle(1'b1, 1'b0);

    // Reset mid-frame, then a clean full frame from index 0.
    run_frame(0, -1, 4, cyc, sr);
    repeat (2) cycle(1'b1, 1'b0);
    run_frame(0, -1, -1, cyc, sr);
    repeat (3) cycle(1'b1, 1'b0);

    // Random bank contents and random back-pressure.
    for (int f = 0; f < 4; f++) begin
      preload_random();
      run_frame(3, (f == 2) ? int'($urandom_range(0, N - 1)) : -1, -1, cyc, sr);
      repeat (int'($urandom_range(1, 4))) cycle(1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (2) cycle(1'b1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
